spi_slave_core: RTL and testbench

//  Synthesizable SPI slave for all four CPOL/CPHA modes, selected at run time.

---
 rtl/spi_slave_core.sv | 195 +++++++++++++++++++
 tb/tb_spi_slave_core.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI slave for all four CPOL/CPHA modes with run-time mode select, parameterised word
// width and bit order; SPI pins are oversampled and edge-detected in the clk domain.
module spi_slave_core #(
    parameter int DATA_W      = 8,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sck_i,
    input  logic              csn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort,
    output logic              busy
);
    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    function automatic logic [DATA_W-1:0] rx_shift_in(input logic [DATA_W-1:0] r,
                                                      input logic b);
        logic [DATA_W:0] t;
        if (LSB_FIRST != 0) begin
            t = {b, r};
            return t[DATA_W:1];
        end else begin
            t = {r, b};
            return t[DATA_W-1:0];
        end
    endfunction

    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] s);
        logic [DATA_W:0] t;
        if (LSB_FIRST != 0) begin
            t = {1'b0, s};
            return t[DATA_W:1];
        end else begin
            t = {s, 1'b0};
            return t[DATA_W-1:0];
        end
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic                   sck_s, csn_s, mosi_s;

    state_e            state_q, state_d;
    logic              armed_q, cpol_q, cpha_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              hold_full_q;
    logic [DATA_W-1:0] hold_q, tx_shift_q, rx_shift_q, rx_data_q;
    logic              rx_valid_q, underrun_q, abort_q;

    logic              start, stop;
    logic              sck_rise, sck_fall, lead_edge, trail_edge;
    logic              sample_evt, shift_evt, load_evt, advance_evt;
    logic              tx_xfer, load_ok;
    logic [DATA_W-1:0] load_word, rx_next;

    // csn chain resets low so a mid-frame reset cannot re-arm until csn is truly seen high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_prev_q  <= sck_s;
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !csn_s) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (csn_s) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign lead_edge  = cpol_q ? sck_fall : sck_rise;
    assign trail_edge = cpol_q ? sck_rise : sck_fall;

    assign sample_evt  = (state_q == ACTIVE) && !stop && (cpha_q ? trail_edge : lead_edge);
    assign shift_evt   = (state_q == ACTIVE) && !stop && (cpha_q ? lead_edge : trail_edge);
    // A shift edge with no bits yet counted starts a new word rather than advancing one
    assign load_evt    = (start && !cpha) || (shift_evt && (bit_cnt_q == '0));
    assign advance_evt = shift_evt && (bit_cnt_q != '0);

    assign tx_xfer   = tx_valid && !hold_full_q;
    assign load_ok   = hold_full_q || tx_valid;
    assign load_word = hold_full_q ? hold_q : tx_data;
    assign rx_next   = rx_shift_in(rx_shift_q, mosi_s);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            if (csn_s) armed_q <= 1'b1;
            if (start) begin
                cpol_q    <= cpol;
                cpha_q    <= cpha;
                bit_cnt_q <= '0;
            end
            if (stop) begin
                bit_cnt_q <= '0;
                abort_q   <= (bit_cnt_q != '0);
            end
            if (sample_evt) begin
                rx_shift_q <= rx_next;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q  <= '0;
                    rx_data_q  <= rx_next;
                    rx_valid_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end
            // A handshake in the same cycle as a load feeds that load directly
            if (load_evt) begin
                hold_full_q <= 1'b0;
                underrun_q  <= !load_ok;
                tx_shift_q  <= load_ok ? load_word : '0;
            end else begin
                if (advance_evt) tx_shift_q <= tx_advance(tx_shift_q);
                if (tx_xfer) begin
                    hold_q      <= tx_data;
                    hold_full_q <= 1'b1;
                end
            end
        end
    end

    assign miso_o      = (state_q == ACTIVE) ?
                         ((LSB_FIRST != 0) ? tx_shift_q[0] : tx_shift_q[DATA_W-1]) : 1'b0;
    assign miso_oe     = (state_q == ACTIVE);
    assign busy        = (state_q == ACTIVE);
    assign tx_ready    = !hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: table of mode/frame vectors, hand-written reset and 16-bit
// LSB-first sequences, and random frames checked against a word-level model.
`timescale 1ns/1ps
module tb_spi_slave_core;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpol = 1'b0, cpha = 1'b0, sck = 1'b0, mosi = 1'b0;
    logic csn_a = 1'b1, csn_b = 1'b1;

    logic [7:0]  tx_data_a = '0, rx_data_a;
    logic        tx_valid_a = 1'b0, tx_ready_a, rx_valid_a, tx_underrun_a, frame_abort_a;
    logic        busy_a, miso_a, miso_oe_a;
    logic [15:0] tx_data_b = '0, rx_data_b;
    logic        tx_valid_b = 1'b0, tx_ready_b, rx_valid_b, tx_underrun_b, frame_abort_b;
    logic        busy_b, miso_b, miso_oe_b;

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_W(8), .LSB_FIRST(0), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
        .sck_i(sck), .csn_i(csn_a), .mosi_i(mosi),
        .miso_o(miso_a), .miso_oe(miso_oe_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .tx_underrun(tx_underrun_a), .frame_abort(frame_abort_a), .busy(busy_a)
    );

    spi_slave_core #(.DATA_W(16), .LSB_FIRST(1), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
        .sck_i(sck), .csn_i(csn_b), .mosi_i(mosi),
        .miso_o(miso_b), .miso_oe(miso_oe_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .tx_underrun(tx_underrun_b), .frame_abort(frame_abort_b), .busy(busy_b)
    );

    // Pulse monitors: cumulative counts, tests work on differences
    int         rxcnt_a = 0, urcnt_a = 0, abcnt_a = 0, rxcnt_b = 0, urcnt_b = 0, abcnt_b = 0;
    logic [7:0] rxq_a[$];
    always @(negedge clk) begin
        if (rx_valid_a) begin
            rxcnt_a++;
            rxq_a.push_back(rx_data_a);
        end
        if (tx_underrun_a) urcnt_a++;
        if (frame_abort_a) abcnt_a++;
        if (rx_valid_b) rxcnt_b++;
        if (tx_underrun_b) urcnt_b++;
        if (frame_abort_b) abcnt_b++;
    end

    // tx feeders: present txbuf words in order; a reset drops whatever is pending
    logic [7:0]  txbuf_a[$];
    logic [15:0] txbuf_b[$];
    int ptr_a = 0, ptr_b = 0;
    bit rdy_seen_a = 1'b0, rdy_seen_b = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) ptr_a = txbuf_a.size();
        else if (tx_valid_a && rdy_seen_a) ptr_a++;
        rdy_seen_a = tx_ready_a && rst_n;
        tx_valid_a = (ptr_a < txbuf_a.size());
        tx_data_a  = tx_valid_a ? txbuf_a[ptr_a] : 8'h00;
        if (!rst_n) ptr_b = txbuf_b.size();
        else if (tx_valid_b && rdy_seen_b) ptr_b++;
        rdy_seen_b = tx_ready_b && rst_n;
        tx_valid_b = (ptr_b < txbuf_b.size());
        tx_data_b  = tx_valid_b ? txbuf_b[ptr_b] : 16'h0000;
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic miso_sel(input bit b);
        return b ? miso_b : miso_a;
    endfunction

    task automatic csn_set(input bit b, input logic v);
        if (b) csn_b = v;
        else   csn_a = v;
    endtask

    // Master: bits of mo sent from bit nb-1 down to 0; mi collects miso in arrival order
    task automatic clock_bits(input bit b, input int nb, input logic [63:0] mo,
                              output logic [63:0] mi);
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            if (!cpha) begin
                mosi = mo[nb-1-i];
                tick(H); sck = ~cpol; mi = {mi[62:0], miso_sel(b)};
                tick(H); sck = cpol;
            end else begin
                tick(H); sck = ~cpol; mosi = mo[nb-1-i];
                tick(H); sck = cpol; mi = {mi[62:0], miso_sel(b)};
            end
        end
    endtask

    task automatic run_frame(input bit b, input logic [1:0] mode, input int nb,
                             input logic [63:0] mo, output logic [63:0] mi);
        cpol = mode[1]; cpha = mode[0]; sck = mode[1];
        tick(2*H);
        csn_set(b, 1'b0);
        tick(H);
        clock_bits(b, nb, mo, mi);
        tick(H);
        csn_set(b, 1'b1);
        tick(2*H);
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    typedef struct {
        logic [1:0]  mode;
        int          nb;
        int          ntx;
        logic [7:0]  tx0, tx1;
        logic [15:0] mo, exp_mi;
        logic [7:0]  exp_rx;
        int          exp_rxn, exp_ur, exp_ab;
    } vec_t;
    vec_t vt[8];

    logic [63:0] mi, mo, exp_mi;
    logic [1:0]  mode;
    logic [7:0]  tw[5], w;
    int base_rx, base_ur, base_ab, base_q, nb, ntx, full, nload;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        mode   nb  ntx  tx0    tx1    mosi      miso      rx    rxn ur ab
        vt[0] = '{2'd0,  8, 1, 8'hA5, 8'h00, 16'h003C, 16'h00A5, 8'h3C, 1, 1, 0};
        vt[1] = '{2'd1,  8, 1, 8'hA5, 8'h00, 16'h003C, 16'h00A5, 8'h3C, 1, 0, 0};
        vt[2] = '{2'd2,  8, 1, 8'hA5, 8'h00, 16'h003C, 16'h00A5, 8'h3C, 1, 1, 0};
        vt[3] = '{2'd3,  8, 1, 8'hA5, 8'h00, 16'h003C, 16'h00A5, 8'h3C, 1, 0, 0};
        vt[4] = '{2'd3, 16, 2, 8'h12, 8'h34, 16'h3C5A, 16'h1234, 8'h5A, 2, 0, 0};
        vt[5] = '{2'd3, 16, 1, 8'h55, 8'h00, 16'hAA0F, 16'h5500, 8'h0F, 2, 1, 0};
        vt[6] = '{2'd0,  5, 1, 8'h5A, 8'h00, 16'h0013, 16'h000B, 8'h0F, 0, 0, 1};
        vt[7] = '{2'd0,  8, 1, 8'hC3, 8'h00, 16'h0096, 16'h00C3, 8'h96, 1, 1, 0};

        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(4);
        chk("reset busy",     64'(busy_a),     64'd0);
        chk("reset miso_oe",  64'(miso_oe_a),  64'd0);
        chk("reset miso",     64'(miso_a),     64'd0);
        chk("reset tx_ready", 64'(tx_ready_a), 64'd1);
        chk("reset rx_data",  64'(rx_data_a),  64'd0);
        chk("reset rx_valid", 64'(rx_valid_a), 64'd0);

        for (int k = 0; k < 8; k++) begin
            base_rx = rxcnt_a; base_ur = urcnt_a; base_ab = abcnt_a;
            if (vt[k].ntx > 0) txbuf_a.push_back(vt[k].tx0);
            if (vt[k].ntx > 1) txbuf_a.push_back(vt[k].tx1);
            run_frame(1'b0, vt[k].mode, vt[k].nb, 64'(vt[k].mo), mi);
            chk($sformatf("vec%0d miso", k),     mi,                         64'(vt[k].exp_mi));
            chk($sformatf("vec%0d rx_data", k),  64'(rx_data_a),             64'(vt[k].exp_rx));
            chk($sformatf("vec%0d rx_valid", k), 64'(rxcnt_a - base_rx),     64'(vt[k].exp_rxn));
            chk($sformatf("vec%0d underrun", k), 64'(urcnt_a - base_ur),     64'(vt[k].exp_ur));
            chk($sformatf("vec%0d abort", k),    64'(abcnt_a - base_ab),     64'(vt[k].exp_ab));
        end

        // 16-bit LSB-first instance: 0xBEEF in, 0x1234 out, both LSB first on the wire
        base_rx = rxcnt_b; base_ur = urcnt_b; base_ab = abcnt_b;
        txbuf_b.push_back(16'h1234);
        run_frame(1'b1, 2'd0, 16, 64'(rev16(16'hBEEF)), mi);
        chk("w16 rx_data",  64'(rx_data_b),          64'hBEEF);
        chk("w16 miso",     64'(rev16(mi[15:0])),    64'h1234);
        chk("w16 rx_valid", 64'(rxcnt_b - base_rx),  64'd1);
        chk("w16 underrun", 64'(urcnt_b - base_ur),  64'd1);
        chk("w16 abort",    64'(abcnt_b - base_ab),  64'd0);

        // Reset in mid-word, then traffic while csn stays low must be ignored
        txbuf_a.push_back(8'h11);
        txbuf_a.push_back(8'h22);
        cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
        tick(2*H);
        csn_a = 1'b0;
        tick(H);
        clock_bits(1'b0, 4, 64'h0F, mi);
        tick(2);
        chk("midframe busy",     64'(busy_a),     64'd1);
        chk("midframe miso_oe",  64'(miso_oe_a),  64'd1);
        chk("midframe tx_ready", 64'(tx_ready_a), 64'd0);
        rst_n = 1'b0;
        tick(3);
        chk("rst busy",     64'(busy_a),        64'd0);
        chk("rst miso_oe",  64'(miso_oe_a),     64'd0);
        chk("rst miso",     64'(miso_a),        64'd0);
        chk("rst tx_ready", 64'(tx_ready_a),    64'd1);
        chk("rst rx_data",  64'(rx_data_a),     64'd0);
        chk("rst rx_valid", 64'(rx_valid_a),    64'd0);
        chk("rst underrun", 64'(tx_underrun_a), 64'd0);
        chk("rst abort",    64'(frame_abort_a), 64'd0);
        rst_n = 1'b1;
        base_rx = rxcnt_a; base_ur = urcnt_a; base_ab = abcnt_a;
        clock_bits(1'b0, 8, 64'h5A, mi);
        chk("post-rst busy",     64'(busy_a),              64'd0);
        chk("post-rst miso_oe",  64'(miso_oe_a),           64'd0);
        tick(H);
        csn_a = 1'b1;
        tick(2*H);
        chk("post-rst rx_valid", 64'(rxcnt_a - base_rx),   64'd0);
        chk("post-rst abort",    64'(abcnt_a - base_ab),   64'd0);
        chk("post-rst underrun", 64'(urcnt_a - base_ur),   64'd0);
        txbuf_a.push_back(8'h77);
        base_rx = rxcnt_a;
        run_frame(1'b0, 2'd1, 8, 64'hE1, mi);
        chk("rearm miso",     mi,                       64'h77);
        chk("rearm rx_data",  64'(rx_data_a),           64'hE1);
        chk("rearm rx_valid", 64'(rxcnt_a - base_rx),   64'd1);

        // Random frames: model works on whole words and the load count implied by the mode
        for (int r = 0; r < 10; r++) begin
            mode  = 2'($urandom_range(0, 3));
            nb    = int'($urandom_range(1, 32));
            full  = nb / 8;
            nload = mode[0] ? (nb + 7) / 8 : 1 + full;
            ntx   = int'($urandom_range(0, nload));
            for (int j = 0; j < ntx; j++) begin
                tw[j] = 8'($urandom);
                txbuf_a.push_back(tw[j]);
            end
            mo = 64'($urandom);
            exp_mi = '0;
            for (int i = 0; i < nb; i++) begin
                w = (i / 8 < ntx) ? tw[i/8] : 8'h00;
                exp_mi = {exp_mi[62:0], w[7 - (i % 8)]};
            end
            base_rx = rxcnt_a; base_ur = urcnt_a; base_ab = abcnt_a; base_q = rxq_a.size();
            run_frame(1'b0, mode, nb, mo, mi);
            chk($sformatf("rnd%0d miso", r),     mi,                     exp_mi);
            chk($sformatf("rnd%0d rx_valid", r), 64'(rxcnt_a - base_rx), 64'(full));
            chk($sformatf("rnd%0d underrun", r), 64'(urcnt_a - base_ur), 64'(nload - ntx));
            chk($sformatf("rnd%0d abort", r),    64'(abcnt_a - base_ab), 64'((nb % 8) != 0));
            for (int k = 0; k < full; k++) begin
                if (base_q + k < rxq_a.size())
                    chk($sformatf("rnd%0d word%0d", r, k), 64'(rxq_a[base_q + k]),
                        (mo >> (nb - 8 * (k + 1))) & 64'hFF);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
